ternary_sampler: RTL
====================

# ternary_sampler

Consumes the 256-bit `coins` word produced by the free-running LFSR and turns it into the ternary polynomial stream required by NTRU-HRSS `sample_iid`. Each coin byte is reduced mod 3 to one coefficient. Coefficients 0..N-2 come from consecutive bytes, and coefficient N-1 is forced to 0. Output is a valid/ready coefficient stream to the polynomial RAM writer.

## Interface
- `N`, default 701: polynomial length; coefficients are emitted with idx 0..N-1.
- `COIN_W`, default 256: coin word width; must be a multiple of 8.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin one polynomial; sampled only in IDLE.
- `coins`  in  COIN_W  LFSR output, captured as-is when needed (the LFSR has no enable).
- `coin_cap`  out  1  high in the cycle whose closing edge captures `coins`.
- `coeff`  out  2  ternary coefficient; encoding is set under Configuration.
- `coeff_idx`  out  10  index of `coeff`, 0..N-1.
- `coeff_valid`  out  1  `coeff` and `coeff_idx` are valid.
- `coeff_ready`  in  1  consumer accepts the coefficient.
- `coeff_last`  out  1  high together with `coeff_valid` when idx = N-1.
- `busy`  out  1  high whenever not in IDLE.
- `done`  out  1  one-cycle pulse after the last handshake.

## Operation
- States and transitions:
  - IDLE: waits for `start`; goes to LOAD on `start`.
  - LOAD: one cycle with `coin_cap`=1; the buffer captures `coins` and byte pointer `bp` is cleared to 0.
  - EMIT: presents a coefficient; see the handshake rules below.
  - FINAL: presents idx N-1 with `coeff`=0 and `coeff_last`=1.
  - DONE: one cycle with `done`=1, then returns to IDLE.
- Byte k of the buffer is `buf[8k+7:8k]`, consumed in LSB-first order.
- In EMIT, `coeff` = mod3(`buf` byte `bp`), computed combinationally from the registered buffer.
- On an EMIT handshake (`coeff_valid` & `coeff_ready`), `bp` and idx both increment.
  - If idx was N-2, the next state is FINAL.
  - Else if `bp` was COIN_W/8-1, the next state is LOAD.
  - Otherwise the state stays EMIT.
- FINAL consumes no byte. On its handshake the next state is DONE.
- Bytes left over in the final buffer are discarded. For N=701: 700 bytes are used, over 22 loads, and the last load uses 28 of 32 bytes.
- With no handshake, `coeff`, `coeff_idx` and `coeff_valid` hold stable; the stream is never withdrawn.
- `start` while `busy` is ignored. `start` in the same cycle as `done` is also ignored; it is accepted from IDLE only.
- `rst` at any point, including mid-polynomial, has these effects:
  - The next state is IDLE.
  - All outputs become 0, and the buffer, `bp` and idx are cleared.
  - The partial polynomial is abandoned with no `done`.

## Timing
- Reset values: `coin_cap`=0, `coeff`=0, `coeff_idx`=0, `coeff_valid`=0, `coeff_last`=0, `busy`=0, `done`=0.
- `start` sampled at edge E0:
  - LOAD is the state during cycle 1.
  - `coins` is captured at E1.
  - `coeff_valid`=1 from cycle 2.
- Each reload inserts exactly one bubble cycle with `coeff_valid`=0.
- With `coeff_ready` tied to 1, one polynomial takes 22 LOAD + 701 emit cycles + 1 DONE cycle = 724 cycles from E0 to the `done` cycle inclusive.
- All outputs are registered or derive from registered state only. There is no combinational path from `coeff_ready` to any output.

## Configuration
- `TERNARY_SIGNED_EN` defined: `coeff` is 2-bit two's complement, giving 0→2'b00, 1→2'b01, 2→2'b11 (that is, -1).
- Not defined: `coeff` is unsigned 2'b00/2'b01/2'b10.
- The forced last coefficient is 2'b00 in both modes.

## Structure
- Package `ntru_pkg` holds:
  - `NTRU_N`=701 and `COIN_W`=256;
  - `IDX_W`=10;
  - the state enum `sampler_state_t` (IDLE, LOAD, EMIT, FINAL, DONE);
  - the coefficient encoding constants for both modes.
- Sub-module `mod3_byte`: combinational 8-bit → 2-bit remainder mod 3, built as a fold of bit pairs, no divider.

## Test plan
- Drive `coins`=all 0xFF bytes, pulse `start`, `coeff_ready`=1 → 700 coefficients of 0, then idx 700 = 0 with `coeff_last`; `done` at cycle 724.
- Drive byte0=0x02, byte1=0x04, byte2=0x80, byte3=0x00 → coeffs 2, 1, 2, 0 (signed build: 2'b11, 2'b01, 2'b11, 2'b00).
- Change `coins` every cycle → `coin_cap` high exactly 22 times; each captured value matches the byte stream; bubbles fall at idx 32, 64, …, 672.
- Hold `coeff_ready`=0 for 5 cycles at idx 31 → `coeff` and `coeff_idx` stay stable; no reload until the handshake.
- Assert `rst` at idx 300 → all outputs 0 next cycle, no `done`; a fresh `start` restarts at idx 0.
- Pulse `start` at idx 10 → ignored; exactly one `done` per polynomial.

Source files
------------

// File: rtl/ntru_pkg.sv
// Shared constants and types for the NTRU-HRSS ternary sampler.
package ntru_pkg;

    localparam int NTRU_N = 701;
    localparam int COIN_W = 256;
    localparam int IDX_W  = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EMIT,
        FINAL,
        DONE
    } sampler_state_t;

    // Unsigned coefficient encoding: 0, 1, 2
    localparam logic [1:0] COEF_ZERO   = 2'b00;
    localparam logic [1:0] COEF_U_ONE  = 2'b01;
    localparam logic [1:0] COEF_U_TWO  = 2'b10;

    // Two's complement coefficient encoding: 0, 1, -1
    localparam logic [1:0] COEF_S_ONE  = 2'b01;
    localparam logic [1:0] COEF_S_MONE = 2'b11;

endpackage

// File: rtl/mod3_byte.sv
// Combinational byte mod 3. Since 4 == 1 (mod 3), a byte reduces to the
// sum of its four bit pairs; the sum is folded pairwise until it fits in
// two bits, and the residue 3 maps to 0.
module mod3_byte (
    input  logic [7:0] din,
    output logic [1:0] rem
);

    logic [3:0] s1;
    logic [2:0] s2;
    logic [1:0] s3;

    // Fold bit pairs: 0..12 -> 0..5 -> 0..3 -> residue
    always_comb begin
        s1  = {2'b00, din[1:0]} + {2'b00, din[3:2]}
            + {2'b00, din[5:4]} + {2'b00, din[7:6]};
        s2  = {1'b0, s1[3:2]} + {1'b0, s1[1:0]};
        s3  = {1'b0, s2[2]} + s2[1:0];
        rem = (s3 == 2'd3) ? 2'b00 : s3;
    end

endmodule

// File: rtl/ternary_sampler.sv
// Turns LFSR coin words into the NTRU-HRSS sample_iid ternary stream.
// One byte per coefficient (mod 3), coefficient N-1 forced to zero.
// Optional feature macro: TERNARY_SIGNED_EN selects two's complement
// coefficient encoding (2 -> 2'b11); otherwise coefficients are unsigned.
module ternary_sampler
    import ntru_pkg::*;
#(
    parameter int N      = NTRU_N,
    parameter int COIN_W = ntru_pkg::COIN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [COIN_W-1:0] coins,
    output logic              coin_cap,
    output logic [1:0]        coeff,
    output logic [IDX_W-1:0]  coeff_idx,
    output logic              coeff_valid,
    input  logic              coeff_ready,
    output logic              coeff_last,
    output logic              busy,
    output logic              done
);

    localparam int BYTES = COIN_W / 8;
    localparam int BP_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [BP_W-1:0]  BP_LAST    = BP_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_PENULT = IDX_W'(N - 2);

    sampler_state_t    state_q, state_d;
    logic [COIN_W-1:0] coin_buf_q;
    logic [BP_W-1:0]   bp_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        cur_byte;
    logic [1:0]        rem;
    logic              hs;

    function automatic logic [1:0] encode(input logic [1:0] r);
`ifdef TERNARY_SIGNED_EN
        case (r)
            2'd1:    return COEF_S_ONE;
            2'd2:    return COEF_S_MONE;
            default: return COEF_ZERO;
        endcase
`else
        case (r)
            2'd1:    return COEF_U_ONE;
            2'd2:    return COEF_U_TWO;
            default: return COEF_ZERO;
        endcase
`endif
    endfunction

    assign cur_byte = coin_buf_q[{bp_q, 3'b000} +: 8];

    mod3_byte u_mod3 (
        .din (cur_byte),
        .rem (rem)
    );

    // Next state and outputs, decoded from registered state only
    always_comb begin
        state_d     = state_q;
        coin_cap    = 1'b0;
        coeff       = COEF_ZERO;
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        hs          = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                coin_cap = 1'b1;
                state_d  = EMIT;
            end
            EMIT: begin
                coeff_valid = 1'b1;
                coeff       = encode(rem);
                hs          = coeff_ready;
                if (hs) begin
                    if (idx_q == IDX_PENULT)  state_d = FINAL;
                    else if (bp_q == BP_LAST) state_d = LOAD;
                end
            end
            FINAL: begin
                coeff_valid = 1'b1;
                coeff_last  = 1'b1;
                if (coeff_ready) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign coeff_idx = idx_q;

    // State, coin buffer, byte pointer and index registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            coin_buf_q <= '0;
            bp_q       <= '0;
            idx_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                LOAD: begin
                    coin_buf_q <= coins;
                    bp_q       <= '0;
                end
                EMIT: begin
                    if (hs) begin
                        bp_q  <= bp_q + BP_W'(1);
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: idx_q <= '0;
                default: ;
            endcase
        end
    end

endmodule
